// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port RAM between the
// instruction-fetch path (i_if_*) and the load/store path (i_ls_*).
// Grants combinationally, drives the RAM command (o_mem_*), and pulses
// o_if_rvalid / o_ls_rvalid one enabled cycle after a read grant.
// Read data (o_*_rdata) is a straight pass-through of i_mem_rdata.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin instead of
// data-first priority with a fetch starvation limit.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31,
  parameter int STREAK_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH:0]   i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH:0]   o_if_rdata,
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [3:0]            i_ls_be,
  input  logic [ADDR_WIDTH:0]   i_ls_addr,
  input  logic [DATA_WIDTH:0]   i_ls_wdata,
  output logic                  o_ls_gnt,
  output logic                  o_ls_rvalid,
  output logic [DATA_WIDTH:0]   o_ls_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic [DATA_WIDTH:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  owner_t owner_q, owner_d;
  logic   live;
  logic   if_win;

  assign live = clk_en & ~rst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_fetch_q;

  assign if_win = ~last_fetch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_fetch_q <= 1'b1;
    end else if (clk_en && (o_if_gnt || o_ls_gnt)) begin
      last_fetch_q <= o_if_gnt;
    end
  end
`else
  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);
  logic [3:0] streak_q;

  assign if_win = (streak_q == STREAK_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (clk_en) begin
      if (!i_if_req || o_if_gnt) begin
        streak_q <= '0;
      end else if (o_ls_gnt && (streak_q != STREAK_LIM)) begin
        streak_q <= streak_q + 4'd1;
      end
    end
  end
`endif

  always_comb begin
    o_if_gnt = 1'b0;
    o_ls_gnt = 1'b0;
    if (live) begin
      if (i_if_req && i_ls_req) begin
        o_if_gnt = if_win;
        o_ls_gnt = ~if_win;
      end else begin
        o_if_gnt = i_if_req;
        o_ls_gnt = i_ls_req;
      end
    end
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (o_if_gnt) begin
      o_mem_be   = '1;
      o_mem_addr = i_if_addr;
    end else if (o_ls_gnt) begin
      o_mem_we    = i_ls_we;
      o_mem_be    = i_ls_we ? i_ls_be : 4'b1111;
      o_mem_addr  = i_ls_addr;
      o_mem_wdata = i_ls_wdata;
    end
  end

  assign o_mem_en = o_if_gnt | o_ls_gnt;

  always_comb begin
    owner_d = OWN_NONE;
    if (o_if_gnt) begin
      owner_d = OWN_IF;
    end else if (o_ls_gnt && !i_ls_we) begin
      owner_d = OWN_LS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else if (clk_en) begin
      owner_q <= owner_d;
    end
  end

  // Owner is held through clk_en stalls, so the pulse lands on the next
  // enabled cycle; the RAM output is held by the same enable.
  assign o_if_rvalid = live && (owner_q == OWN_IF);
  assign o_ls_rvalid = live && (owner_q == OWN_LS);
  assign o_if_rdata  = i_mem_rdata;
  assign o_ls_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int STREAK_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, clk_en;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [3:0]  ls_be;
  logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_if_rdata, o_ls_rdata;
  logic        o_mem_en, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_be(ls_be), .i_ls_addr(ls_addr),
    .i_ls_wdata(ls_wdata), .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid),
    .o_ls_rdata(o_ls_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] fill_word(int i);
    return (32'h1000_0001 * i) ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Environment RAM: 32 words, clocked with the same enable as the arbiter.
  logic [31:0] ram [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ram[i] <= fill_word(i);
    end else if (clk_en && o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr[4:0]] <= merge(ram[o_mem_addr[4:0]], o_mem_wdata, o_mem_be);
      else          mem_rdata <= ram[o_mem_addr[4:0]];
    end
  end

  // Reference model
  int unsigned m_streak;
  bit          m_last_fetch, m_pend_if, m_pend_ls;
  logic [31:0] m_pend_data;
  logic [31:0] ref_mem [32];
  bit          e_if_gnt, e_ls_gnt, e_en, e_we, e_if_rv, e_ls_rv;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;

  task automatic model_eval();
    bit fetch_first;
    e_if_gnt = 0;
    e_ls_gnt = 0;
    if (clk_en && !rst) begin
      if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        fetch_first = !m_last_fetch;
`else
        fetch_first = (m_streak == STREAK_MAX);
`endif
        e_if_gnt = fetch_first;
        e_ls_gnt = !fetch_first;
      end else begin
        e_if_gnt = if_req;
        e_ls_gnt = ls_req;
      end
    end
    e_en    = e_if_gnt || e_ls_gnt;
    e_we    = e_ls_gnt && ls_we;
    e_be    = e_if_gnt ? 4'hF : (e_ls_gnt ? (ls_we ? ls_be : 4'hF) : 4'h0);
    e_addr  = e_if_gnt ? if_addr : (e_ls_gnt ? ls_addr : 32'h0);
    e_wdata = e_ls_gnt ? ls_wdata : 32'h0;
    e_if_rv = clk_en && !rst && m_pend_if;
    e_ls_rv = clk_en && !rst && m_pend_ls;
  endtask

  task automatic model_tick();
    if (rst) begin
      m_streak = 0; m_last_fetch = 1; m_pend_if = 0; m_pend_ls = 0;
      for (int i = 0; i < 32; i++) ref_mem[i] = fill_word(i);
    end else if (clk_en) begin
      if (e_en && !e_we) m_pend_data = ref_mem[e_addr[4:0]];
      if (e_we) ref_mem[e_addr[4:0]] = merge(ref_mem[e_addr[4:0]], ls_wdata, ls_be);
      m_pend_if = e_if_gnt;
      m_pend_ls = e_ls_gnt && !ls_we;
      if (!if_req || e_if_gnt) m_streak = 0;
      else if (e_ls_gnt && m_streak < STREAK_MAX) m_streak++;
      if (e_en) m_last_fetch = e_if_gnt;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; ls_req = 0; ls_we = 0; ls_be = 4'h0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; clk_en = 1;
    sample(); advance();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; clk_en = 1; if_req = 1; ls_req = 1;
    sample(); advance();
    sample();
    vectors++; if (o_if_gnt !== 1'b0 || o_ls_gnt !== 1'b0) begin miscompares++;
      $display("FAIL reset_gnt got if=%b ls=%b exp 0 0", o_if_gnt, o_ls_gnt); end
    vectors++; if (o_mem_en !== 1'b0) begin miscompares++;
      $display("FAIL reset_mem_en got %b exp 0", o_mem_en); end
    vectors++; if (o_if_rvalid !== 1'b0 || o_ls_rvalid !== 1'b0) begin miscompares++;
      $display("FAIL reset_rvalid got if=%b ls=%b exp 0 0", o_if_rvalid, o_ls_rvalid); end
    advance();
    rst = 0; idle_inputs();
  endtask

  task automatic test_fetch_read();
    ls_req = 1; ls_we = 1; ls_be = 4'hF; ls_addr = 32'h10; ls_wdata = 32'hDEADBEEF;
    sample();
    vectors++; if (o_ls_gnt !== 1'b1 || o_mem_we !== 1'b1) begin miscompares++;
      $display("FAIL preload_store got gnt=%b we=%b exp 1 1", o_ls_gnt, o_mem_we); end
    advance();
    idle_inputs(); if_req = 1; if_addr = 32'h10;
    sample();
    vectors++; if (o_if_gnt !== 1'b1 || o_mem_addr !== 32'h10 || o_mem_be !== 4'hF || o_mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_cmd got gnt=%b addr=%h be=%h we=%b exp 1 10 f 0", o_if_gnt, o_mem_addr, o_mem_be, o_mem_we); end
    advance();
    idle_inputs();
    sample();
    vectors++; if (o_if_rvalid !== 1'b1 || o_if_rdata !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL fetch_return got rv=%b data=%h exp 1 deadbeef", o_if_rvalid, o_if_rdata); end
    vectors++; if (o_ls_rvalid !== 1'b0) begin miscompares++;
      $display("FAIL fetch_ls_rvalid got %b exp 0", o_ls_rvalid); end
    advance();
  endtask

  task automatic test_store();
    idle_inputs();
    ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h20; ls_wdata = 32'h1234;
    sample();
    vectors++; if (o_mem_en !== 1'b1 || o_mem_we !== 1'b1 || o_mem_be !== 4'b0011 ||
                   o_mem_addr !== 32'h20 || o_mem_wdata !== 32'h1234) begin miscompares++;
      $display("FAIL store_cmd got en=%b we=%b be=%b addr=%h wd=%h exp 1 1 0011 20 1234",
               o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata); end
    advance();
    idle_inputs();
    sample();
    vectors++; if (o_if_rvalid !== 1'b0 || o_ls_rvalid !== 1'b0) begin miscompares++;
      $display("FAIL store_no_rvalid got if=%b ls=%b exp 0 0", o_if_rvalid, o_ls_rvalid); end
    advance();
    ls_req = 1; ls_addr = 32'h20;
    sample(); advance();
    idle_inputs();
    sample();
    vectors++; if (o_ls_rvalid !== 1'b1 || o_ls_rdata !== m_pend_data || o_ls_rdata[15:0] !== 16'h1234) begin
      miscompares++;
      $display("FAIL store_readback got rv=%b data=%h exp 1 %h", o_ls_rvalid, o_ls_rdata, m_pend_data); end
    advance();
  endtask

  // Both requesters continuously active; grants follow a fixed period.
  task automatic contention(string tag, int n);
    bit prev_f = 0;
    bit exp_f;
    if_req = 1; if_addr = 32'h3; ls_req = 1; ls_we = 0; ls_addr = 32'h7;
    for (int k = 0; k < n; k++) begin
      sample();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_f = (k % 2) == 1;
`else
      exp_f = (k % (STREAK_MAX + 1)) == STREAK_MAX;
`endif
      vectors++; if (o_if_gnt !== exp_f || o_ls_gnt !== !exp_f) begin miscompares++;
        $display("FAIL %s_pattern k=%0d got if=%b ls=%b exp if=%b", tag, k, o_if_gnt, o_ls_gnt, exp_f); end
      vectors++; if (o_if_rvalid !== (k > 0 && prev_f)) begin miscompares++;
        $display("FAIL %s_if_rvalid k=%0d got %b exp %b", tag, k, o_if_rvalid, k > 0 && prev_f); end
      prev_f = exp_f;
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_contention();
    do_reset();
    contention("contend", 3 * (STREAK_MAX + 1));
  endtask

  task automatic test_clk_en_stall();
    do_reset();
    if_req = 1; if_addr = 32'h5;
    sample();
    vectors++; if (o_if_gnt !== 1'b1) begin miscompares++;
      $display("FAIL stall_grant got %b exp 1", o_if_gnt); end
    advance();
    clk_en = 0; ls_req = 1; ls_addr = 32'h9;
    for (int k = 0; k < 2; k++) begin
      sample();
      vectors++; if (o_if_gnt | o_ls_gnt | o_mem_en | o_if_rvalid | o_ls_rvalid) begin miscompares++;
        $display("FAIL stall_quiet k=%0d got gnt=%b%b en=%b rv=%b%b exp all 0",
                 k, o_if_gnt, o_ls_gnt, o_mem_en, o_if_rvalid, o_ls_rvalid); end
      advance();
    end
    clk_en = 1; idle_inputs();
    sample();
    vectors++; if (o_if_rvalid !== 1'b1 || o_if_rdata !== m_pend_data || o_if_rdata !== fill_word(5)) begin
      miscompares++;
      $display("FAIL stall_return got rv=%b data=%h exp 1 %h", o_if_rvalid, o_if_rdata, fill_word(5)); end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_req = 1; if_addr = 32'h2; ls_req = 1; ls_we = 0; ls_addr = 32'h4;
    for (int k = 0; k < 3; k++) begin
      sample();
      vectors++; if (o_ls_gnt !== 1'b1 && k != 1) begin miscompares++;
        $display("FAIL rstmid_pre k=%0d got ls_gnt=%b exp 1", k, o_ls_gnt); end
      advance();
    end
    rst = 1;
    sample();
    vectors++; if (o_ls_rvalid !== 1'b0 || o_if_rvalid !== 1'b0 || o_ls_gnt !== 1'b0) begin miscompares++;
      $display("FAIL rstmid_suppress got lsrv=%b ifrv=%b gnt=%b exp 0 0 0", o_ls_rvalid, o_if_rvalid, o_ls_gnt); end
    advance();
    rst = 0;
    contention("rstmid", STREAK_MAX + 1);
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      sample();
      vectors++; if (o_if_gnt !== e_if_gnt || o_ls_gnt !== e_ls_gnt) begin miscompares++;
        $display("FAIL rnd_gnt c=%0d got %b%b exp %b%b", c, o_if_gnt, o_ls_gnt, e_if_gnt, e_ls_gnt); end
      vectors++; if (o_mem_en !== e_en || o_mem_we !== e_we || o_mem_be !== e_be ||
                     o_mem_addr !== e_addr || o_mem_wdata !== e_wdata) begin miscompares++;
        $display("FAIL rnd_cmd c=%0d got %b %b %h %h %h exp %b %b %h %h %h", c, o_mem_en, o_mem_we,
                 o_mem_be, o_mem_addr, o_mem_wdata, e_en, e_we, e_be, e_addr, e_wdata); end
      vectors++; if (o_if_rvalid !== e_if_rv || o_ls_rvalid !== e_ls_rv) begin miscompares++;
        $display("FAIL rnd_rvalid c=%0d got %b%b exp %b%b", c, o_if_rvalid, o_ls_rvalid, e_if_rv, e_ls_rv); end
      if (e_if_rv || e_ls_rv) begin
        vectors++; if ((e_if_rv ? o_if_rdata : o_ls_rdata) !== m_pend_data) begin miscompares++;
          $display("FAIL rnd_rdata c=%0d got %h exp %h", c, e_if_rv ? o_if_rdata : o_ls_rdata, m_pend_data); end
      end
      advance();
      rst = ($urandom_range(0, 99) < 2);
      clk_en = ($urandom_range(0, 9) != 0);
      if (!(if_req && !e_if_gnt && $urandom_range(0, 15) != 0)) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = $urandom_range(0, 31);
      end
      if (!(ls_req && !e_ls_gnt && $urandom_range(0, 15) != 0)) begin
        ls_req = ($urandom_range(0, 3) != 0);
        ls_we = $urandom_range(0, 1);
        ls_be = 4'($urandom_range(0, 15));
        ls_addr = $urandom_range(0, 31);
        ls_wdata = $urandom;
      end
    end
    rst = 0; clk_en = 1; idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1; clk_en = 1;
    test_reset();
    test_fetch_read();
    test_store();
    test_contention();
    test_clk_en_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
